vote_tally: RTL and testbench

VOTE_TALLY -- requirements
Module: vote_tally

---
 rtl/vote_pkg.sv | 21 ++
 rtl/vote_tally_if.sv | 32 +++
 rtl/sat_counter.sv | 41 ++++
 rtl/vote_tally.sv | 104 ++++++++++
 tb/tb_vote_tally.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: shared definitions for the vote tally block.
//   CW_DEF / TW_DEF : default widths of per-candidate and total counts
//   CAND_A..CAND_D  : candidate codes carried on vote_id
//   state_e         : session state (IDLE, OPEN, CLOSED)
package vote_pkg;

  localparam int CW_DEF = 6;
  localparam int TW_DEF = 8;

  localparam logic [1:0] CAND_A = 2'b00;
  localparam logic [1:0] CAND_B = 2'b01;
  localparam logic [1:0] CAND_C = 2'b10;
  localparam logic [1:0] CAND_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    CLOSED = 2'd2
  } state_e;

endpackage

// File: rtl/vote_tally_if.sv
// vote_tally_if: session control, ballot handshake and result bundle.
//   master : drives start, close, vote_valid, vote_id; observes results
//   slave  : the tally block; drives vote_ready, VA..VD, total, ovf, done
interface vote_tally_if
  import vote_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
);
  logic          start;
  logic          close;
  logic          vote_valid;
  logic [1:0]    vote_id;
  logic          vote_ready;
  logic [CW-1:0] VA;
  logic [CW-1:0] VB;
  logic [CW-1:0] VC;
  logic [CW-1:0] VD;
  logic [TW-1:0] total;
  logic          ovf;
  logic          done;

  modport master (
    output start, close, vote_valid, vote_id,
    input  vote_ready, VA, VB, VC, VD, total, ovf, done
  );

  modport slave (
    input  start, close, vote_valid, vote_id,
    output vote_ready, VA, VB, VC, VD, total, ovf, done
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : add one unless already at all-ones
//   count    : registered count
//   sat      : count is at its maximum value
module sat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign sat   = &count_q;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// vote_tally: four-candidate ballot counter with session control.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vote_tally_if slave port (start/close, ballot handshake,
//              per-candidate counts, total, sticky ovf, done)
//
// state  | meaning
// IDLE   | after reset, no session yet; counts held
// OPEN   | ballots accepted (vote_ready=1)
// CLOSED | session ended; counts final (done=1)
module vote_tally
  import vote_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input logic        clk,
  input logic        rst,
  vote_tally_if.slave bus
);

  state_e        state_q;
  state_e        state_d;
  logic          ovf_q;
  logic          ovf_d;

  logic          clr;
  logic          accept;
  logic [3:0]    inc_c;
  logic [3:0]    sat_c;
  logic          sat_t;
  logic [CW-1:0] cnt [4];
  logic [TW-1:0] tot;

  // Counters clear only on the edge that actually enters OPEN; start while
  // OPEN is ignored.
  assign clr    = bus.start && (state_q != OPEN);
  assign accept = bus.vote_valid && (state_q == OPEN);

  always_comb begin
    inc_c = '0;
    inc_c[bus.vote_id] = accept;
  end

  for (genvar g = 0; g < 4; g++) begin : g_cand
    sat_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .inc   (inc_c[g]),
      .count (cnt[g]),
      .sat   (sat_c[g])
    );
  end

  sat_counter #(.W(TW)) u_total (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (accept),
    .count (tot),
    .sat   (sat_t)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = OPEN;
      OPEN:    if (bus.close) state_d = CLOSED;
      CLOSED:  if (bus.start) state_d = OPEN;
      default: state_d = IDLE;
    endcase
  end

  // A ballot landing on a saturated counter still completes the handshake;
  // it only raises the sticky flag.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (|(inc_c & sat_c) || (accept && sat_t)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.vote_ready = (state_q == OPEN);
  assign bus.done       = (state_q == CLOSED);
  assign bus.ovf        = ovf_q;
  assign bus.VA         = cnt[CAND_A];
  assign bus.VB         = cnt[CAND_B];
  assign bus.VC         = cnt[CAND_C];
  assign bus.VD         = cnt[CAND_D];
  assign bus.total      = tot;

endmodule

// File: tb/tb_vote_tally.sv
// tb_vote_tally: scoreboard bench for vote_tally. The driver predicts the
// post-edge outputs with an arithmetic model of the voting rules and queues
// them; a negedge monitor pops and compares against the DUT.
module tb_vote_tally;
  import vote_pkg::*;

  localparam int CW   = CW_DEF;
  localparam int TW   = TW_DEF;
  localparam int MAXC = (1 << CW) - 1;
  localparam int MAXT = (1 << TW) - 1;

  localparam int M_IDLE   = 0;
  localparam int M_OPEN   = 1;
  localparam int M_CLOSED = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vote_tally_if #(.CW(CW), .TW(TW)) bus ();

  vote_tally #(.CW(CW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int va, vb, vc, vd, tot;
    bit ovf, done, ready;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_cnt[4];
  int m_tot;
  bit m_ovf;
  int m_state;

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_tot = 0;
    m_ovf = 1'b0;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit c, input bit vv,
                     input logic [1:0] id);
    exp_t e;
    rst            = r;
    bus.start      = s;
    bus.close      = c;
    bus.vote_valid = vv;
    bus.vote_id    = id;
    if (r) begin
      m_clear();
      m_state = M_IDLE;
    end else if (m_state == M_OPEN) begin
      if (vv) begin
        if (m_cnt[id] == MAXC) m_ovf = 1'b1; else m_cnt[id]++;
        if (m_tot == MAXT) m_ovf = 1'b1; else m_tot++;
      end
      if (c) m_state = M_CLOSED;
    end else if (s) begin
      m_clear();
      m_state = M_OPEN;
    end
    e.va = m_cnt[0]; e.vb = m_cnt[1]; e.vc = m_cnt[2]; e.vd = m_cnt[3];
    e.tot   = m_tot;
    e.ovf   = m_ovf;
    e.done  = (m_state == M_CLOSED);
    e.ready = (m_state == M_OPEN);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (e.va != bus.VA || e.vb != bus.VB || e.vc != bus.VC || e.vd != bus.VD ||
          e.tot != bus.total || e.ovf != bus.ovf || e.done != bus.done ||
          e.ready != bus.vote_ready) begin
        errors++;
        $display("FAIL scoreboard t=%0t got VA=%0d VB=%0d VC=%0d VD=%0d tot=%0d ovf=%0b done=%0b rdy=%0b expected VA=%0d VB=%0d VC=%0d VD=%0d tot=%0d ovf=%0b done=%0b rdy=%0b",
                 $time, bus.VA, bus.VB, bus.VC, bus.VD, bus.total, bus.ovf, bus.done,
                 bus.vote_ready, e.va, e.vb, e.vc, e.vd, e.tot, e.ovf, e.done, e.ready);
      end
    end
  end

  initial begin
    int ballots[$];
    int idx;
    int tmp;
    int j;
    int lows;

    rst = 1'b1; bus.start = 1'b0; bus.close = 1'b0;
    bus.vote_valid = 1'b0; bus.vote_id = 2'b00;
    m_clear();
    m_state = M_IDLE;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("reset VA", int'(bus.VA), 0);
    chk("reset ready", int'(bus.vote_ready), 0);
    chk("reset done", int'(bus.done), 0);

    // ballots while IDLE are ignored
    repeat (3) cyc(0, 0, 0, 1, CAND_C);
    chk("idle VC", int'(bus.VC), 0);
    chk("idle ready", int'(bus.vote_ready), 0);

    // shuffled session A17 B15 C15 D53 with random gaps
    repeat (17) ballots.push_back(0);
    repeat (15) ballots.push_back(1);
    repeat (15) ballots.push_back(2);
    repeat (53) ballots.push_back(3);
    for (int i = ballots.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = ballots[i]; ballots[i] = ballots[j]; ballots[j] = tmp;
    end
    cyc(0, 1, 0, 0, 0);
    idx = 0;
    while (idx < ballots.size()) begin
      if ($urandom_range(3, 0) != 0) begin
        cyc(0, 0, 0, 1, 2'(ballots[idx]));
        idx++;
      end else begin
        cyc(0, 0, 0, 0, 2'($urandom_range(3, 0)));
      end
    end
    cyc(0, 0, 1, 0, 0);
    chk("mix VA", int'(bus.VA), 17);
    chk("mix VB", int'(bus.VB), 15);
    chk("mix VC", int'(bus.VC), 15);
    chk("mix VD", int'(bus.VD), 53);
    chk("mix total", int'(bus.total), 100);
    chk("mix ovf", int'(bus.ovf), 0);
    chk("mix done", int'(bus.done), 1);

    // ballots while CLOSED are ignored
    repeat (3) cyc(0, 0, 0, 1, CAND_C);
    chk("closed VC", int'(bus.VC), 15);
    chk("closed ready", int'(bus.vote_ready), 0);

    // restart from CLOSED with VA=17
    cyc(0, 1, 0, 0, 0);
    chk("restart VA", int'(bus.VA), 0);
    chk("restart total", int'(bus.total), 0);
    chk("restart done", int'(bus.done), 0);
    chk("restart ready", int'(bus.vote_ready), 1);

    // 70 ballots for D saturate VD
    lows = 0;
    repeat (70) begin
      cyc(0, 0, 0, 1, CAND_D);
      if (bus.vote_ready !== 1'b1) lows++;
    end
    chk("sat ready lows", lows, 0);
    cyc(0, 0, 1, 0, 0);
    chk("sat VD", int'(bus.VD), 63);
    chk("sat ovf", int'(bus.ovf), 1);
    chk("sat total", int'(bus.total), 70);

    // close on same edge as a ballot for B
    cyc(0, 1, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, CAND_B);
    cyc(0, 0, 1, 1, CAND_B);
    chk("closevote VB", int'(bus.VB), 6);
    chk("closevote done", int'(bus.done), 1);
    chk("closevote ready", int'(bus.vote_ready), 0);

    // reset mid-session after 10 ballots
    cyc(0, 1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 1, 2'($urandom_range(3, 0)));
    cyc(1, 1, 1, 1, CAND_A);
    chk("midrst total", int'(bus.total), 0);
    chk("midrst VA", int'(bus.VA), 0);
    chk("midrst ready", int'(bus.vote_ready), 0);
    chk("midrst done", int'(bus.done), 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, CAND_A);
    cyc(0, 0, 1, 0, 0);
    chk("post rst VA", int'(bus.VA), 1);
    chk("post rst total", int'(bus.total), 1);

    // start while OPEN ignored; start+close while OPEN closes
    cyc(0, 1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, CAND_A);
    cyc(0, 1, 0, 1, CAND_A);
    chk("start in open VA", int'(bus.VA), 5);
    cyc(0, 1, 1, 0, 0);
    chk("start+close done", int'(bus.done), 1);

    // total saturation
    cyc(0, 1, 0, 0, 0);
    repeat (300) cyc(0, 0, 0, 1, 2'($urandom_range(3, 0)));
    cyc(0, 0, 1, 0, 0);
    chk("tsat total", int'(bus.total), 255);
    chk("tsat ovf", int'(bus.ovf), 1);

    // random traffic
    repeat (2000) begin
      cyc(($urandom_range(49, 0) == 0), ($urandom_range(9, 0) == 0),
          ($urandom_range(11, 0) == 0), ($urandom_range(3, 0) != 0),
          2'($urandom_range(3, 0)));
    end
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
